paddle_input: RTL
=================

# paddle_input

Input-conditioning stage that sits directly upstream of the Pong game core's paddle logic. It synchronises and debounces the two raw normally-closed push-buttons. It then turns the debounced levels into a clamped, accelerating paddle position in the same 10.6 fixed-point format that the core uses to draw the paddle and test collisions. The core consumes `location` unchanged (integer pixel X = `location[15:6]`).

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable `clk` cycles required before a debounced level changes (minimum 1).
- `PADDLE_WIDTH`, 64: paddle width in pixels.
- `PADDLE_MAX`, 640 - `PADDLE_WIDTH`: largest allowed integer X.
- `PADDLE_RESET`, 288: integer X loaded at reset.
- `STEP_SLOW`, 4: per-tick increment (1/64 px units) before acceleration.
- `STEP_FAST`, 16: per-tick increment after acceleration.
- `ACCEL_TICKS`, 32: move ticks of continuous same-direction hold before switching to `STEP_FAST`.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `buttonLeft`, input, 1: raw left button, normally closed (0 = pressed). Asynchronous and bouncy.
- `buttonRight`, input, 1: raw right button, normally closed (0 = pressed).
- `move_tick`, input, 1: one-cycle enable marking a game tick. Already in the `clk` domain.
- `left_level`, output, 1: debounced left pressed (1 = pressed).
- `right_level`, output, 1: debounced right pressed.
- `left_press`, output, 1: one-cycle pulse on the debounced left 0→1 transition.
- `right_press`, output, 1: one-cycle pulse on the debounced right 0→1 transition.
- `location`, output, 16: paddle X in 10.6 fixed point.

## Operation

- **Synchroniser:** two flops per button. `pressed_sync = ~sync2`.
- **Debounce:** one 16-bit counter per button.
  - If `pressed_sync == level`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `level` toggles on that clock edge and the counter clears.
  - Any single matching cycle restarts the count.
- **Press pulse:** the `*_press` output is high for exactly the cycle after `level` rises. It never asserts on a falling edge.
- **Movement FSM**, evaluated only when `move_tick = 1`. States: STOP, MOVE_INC, MOVE_DEC.
  - Left only → MOVE_INC (`location` increases). Right only → MOVE_DEC. This left-increases mapping is fixed to match the core's paddle convention.
  - Neither button, or both buttons → STOP. No motion, and `hold_cnt` = 0.
  - Direction change: `hold_cnt` = 0, and the step on that tick is `STEP_SLOW`.
  - Same direction as the previous tick: `hold_cnt` increments and saturates at `ACCEL_TICKS`.
  - Step = `STEP_FAST` if `hold_cnt == ACCEL_TICKS`, else `STEP_SLOW`. Use the pre-update value of `hold_cnt`.
  - When `move_tick = 0`, state, `hold_cnt` and `location` all hold.
- **Clamp**, computed in 17 bits, with no wrap-around:
  - MOVE_INC: `location = min(location + step, PADDLE_MAX<<6)`.
  - MOVE_DEC: `location = (location < step) ? 0 : location - step`.
  - At either bound, a further tick leaves `location` unchanged, but `hold_cnt` still advances.
- **Reset** (asynchronous, any time, including mid-debounce or mid-move):
  - `location = PADDLE_RESET<<6` (18432 at defaults).
  - Levels, presses, counters and `hold_cnt` = 0. FSM = STOP. Synchroniser flops = 1 (released).

## Timing

- Raw edge to `*_level` change: 2 synchroniser cycles + `DEBOUNCE_CYCLES` cycles, assuming the input is stable throughout.
- `*_press` is asserted in the same cycle that `*_level` first reads 1, and is deasserted on the next cycle.
- The movement decision uses the `*_level` values registered before the `move_tick` edge. The new `location` is visible one cycle after the tick cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- If a level changes in the same cycle as `move_tick`, that tick uses the old level.

## Test plan

- **Reset values:** assert `rst_n = 0` mid-run. Required: `location` = 18432, all levels and presses = 0, and the values hold while `rst_n` is low.
- **Debounce:** `DEBOUNCE_CYCLES = 8`. Drive `buttonLeft` low with bounces at cycles 3 and 6, then hold it low. Required: `left_level` rises exactly 10 cycles after the last bounce returns low. `left_press` pulses once. Releasing gives no further pulse.
- **Slow and fast step:** hold left with `move_tick` every 4 cycles from X = 288. Required: +4 per tick for ticks 1–33, then +16 per tick from tick 34. Releasing for one tick and re-pressing restores +4.
- **Upper clamp:** set `location` = (575<<6)+60, hold left, and tick. Required: `location` = 36864 (576<<6) and stays there on further ticks.
- **Lower clamp:** from `location` = 2, hold right, and tick. Required: `location` = 0, and no wrap to a large value.
- **Both buttons / reset mid-move:** with both buttons held for 10 ticks, required: `location` unchanged. Asserting `rst_n` low mid-acceleration returns `location` to 18432. After release, the first left tick steps +4.

Source files
------------

// File: rtl/paddle_input.sv
// Paddle input conditioning: synchronise and debounce the two normally-closed
// buttons, then drive a clamped, accelerating 10.6 fixed-point paddle position.
module paddle_input #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          PADDLE_WIDTH    = 64,
    parameter int          PADDLE_MAX      = 640 - PADDLE_WIDTH,
    parameter int          PADDLE_RESET    = 288,
    parameter int          STEP_SLOW       = 4,
    parameter int          STEP_FAST       = 16,
    parameter int          ACCEL_TICKS     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        buttonLeft,
    input  logic        buttonRight,
    input  logic        move_tick,
    output logic        left_level,
    output logic        right_level,
    output logic        left_press,
    output logic        right_press,
    output logic [15:0] location
);

    localparam int                HOLD_W    = $clog2(ACCEL_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(ACCEL_TICKS);
    localparam logic [16:0]       LOC_MAX   = 17'(PADDLE_MAX * 64);
    localparam logic [15:0]       LOC_MAX16 = 16'(PADDLE_MAX * 64);
    localparam logic [15:0]       LOC_RESET = 16'(PADDLE_RESET * 64);
    localparam logic [16:0]       SLOW      = 17'(STEP_SLOW);
    localparam logic [16:0]       FAST      = 17'(STEP_FAST);
    localparam logic [15:0]       DB_LAST   = DEBOUNCE_CYCLES - 16'd1;

    typedef enum logic [1:0] {
        STOP,
        MOVE_INC,
        MOVE_DEC
    } move_state_t;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0]  raw;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  level;
    logic [1:0]  press;
    logic [15:0] db_cnt [2];

    assign raw = {buttonRight, buttonLeft};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            level     <= 2'b00;
            press     <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                press[b] <= 1'b0;
                if (~sync2[b] == level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    level[b]  <= ~level[b];
                    press[b]  <= ~level[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 16'd1;
                end
            end
        end
    end

    move_state_t       state;
    move_state_t       state_next;
    move_state_t       want;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [15:0]       loc_next;
    logic [16:0]       step;
    logic [16:0]       loc_wide;
    logic [16:0]       loc_sum;

    assign loc_wide = {1'b0, location};

    always_comb begin
        want = STOP;
        if (level[0] && !level[1]) begin
            want = MOVE_INC;
        end else if (level[1] && !level[0]) begin
            want = MOVE_DEC;
        end
    end

    // A new direction (including leaving STOP) always restarts at the slow step.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        loc_next   = location;
        step       = SLOW;
        loc_sum    = '0;
        if (move_tick) begin
            state_next = want;
            if (want == STOP || want != state) begin
                hold_next = '0;
            end else if (hold_cnt == HOLD_MAX) begin
                step = FAST;
            end else begin
                hold_next = hold_cnt + 1'b1;
            end
            case (want)
                MOVE_INC: begin
                    loc_sum  = loc_wide + step;
                    loc_next = (loc_sum > LOC_MAX) ? LOC_MAX16 : loc_sum[15:0];
                end
                MOVE_DEC: begin
                    loc_sum  = loc_wide - step;
                    loc_next = (loc_wide < step) ? 16'd0 : loc_sum[15:0];
                end
                default: loc_next = location;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STOP;
            hold_cnt <= '0;
            location <= LOC_RESET;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            location <= loc_next;
        end
    end

    assign left_level  = level[0];
    assign right_level = level[1];
    assign left_press  = press[0];
    assign right_press = press[1];

endmodule
